qpsk_symbol_scheduler: RTL and testbench

Sequences the QPSK modulator datapath.
- Accepts a byte stream over a valid/ready handshake and prepends a fixed preamble.
- Serialises each byte into dibits and drives Ichannel/Qchannel-style bit selects.
- Drives the carrier sample index and symbol strobe that step the symbol waveform tables.
- Sits between the upstream framer and the symbol-selection/output stage, on the single sample clock. It replaces the separate symbol clock.

---
 rtl/qpsk_symbol_scheduler.sv | 84 ++++++++
 tb/tb_qpsk_symbol_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_symbol_scheduler.sv
// qpsk_symbol_scheduler: prepends an alternating preamble and serialises bytes into I/Q dibits on the sample clock
module qpsk_symbol_scheduler #(
  parameter int SPS = 16,
  parameter int PREAMBLE_SYMS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    i_bit,
  output logic                    q_bit,
  output logic [$clog2(SPS)-1:0]  sample_idx,
  output logic                    sym_strobe,
  output logic                    tx_active,
  output logic                    frame_done,
  output logic                    underrun
);
  localparam int SW = $clog2(SPS);
  localparam int CW = PREAMBLE_SYMS > 4 ? $clog2(PREAMBLE_SYMS) : 2;
  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;
  state_t r_state;
  logic [SW-1:0] r_samp;
  logic [CW-1:0] r_sym;
  logic [7:0] r_shift;
  logic r_last, r_done, r_under;
  logic w_sym_end, w_pre_end, w_dat_end, w_byte_bnd;
  // symbol and byte boundary detection from the counters
  always_comb begin
    w_sym_end = r_samp == SW'(SPS - 1);
    w_pre_end = r_state == PRE && r_sym == CW'(PREAMBLE_SYMS - 1);
    w_dat_end = r_state == DATA && r_sym == CW'(3);
    w_byte_bnd = w_sym_end && (w_pre_end || (w_dat_end && !r_last));
  end
  // outputs decoded from registered state only; in_ready never looks at in_valid
  always_comb begin
    in_ready = w_byte_bnd;
    tx_active = r_state != IDLE;
    sample_idx = r_samp;
    sym_strobe = tx_active && r_samp == '0;
    i_bit = r_state == PRE ? r_sym[0] : r_state == DATA && r_shift[7];
    q_bit = r_state == PRE ? r_sym[0] : r_state == DATA && r_shift[6];
    frame_done = r_done;
    underrun = r_under;
  end
  // frame sequencer: idle -> preamble -> data bytes, ending on last byte or missing byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_samp <= '0;
      r_sym <= '0;
      r_shift <= '0;
      r_last <= 1'b0;
      r_done <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_under <= 1'b0;
      if (r_state == IDLE) begin
        r_samp <= '0;
        r_sym <= '0;
        if (in_valid) r_state <= PRE;
      end else begin
        r_samp <= w_sym_end ? '0 : r_samp + 1'b1;
        if (w_sym_end) begin
          if (w_byte_bnd && in_valid) begin
            r_state <= DATA;
            r_sym <= '0;
            r_shift <= in_data;
            r_last <= in_last;
          end else if (w_byte_bnd || w_dat_end) begin
            r_state <= IDLE;
            r_under <= w_byte_bnd;
            r_done <= !w_byte_bnd;
          end else begin
            r_sym <= r_sym + 1'b1;
            r_shift <= r_state == DATA ? r_shift << 2 : r_shift;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_qpsk_symbol_scheduler.sv
// tb_qpsk_symbol_scheduler: trace-level checks of the scheduler against a frame-level reference model
module tb_qpsk_symbol_scheduler;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [7:0] in_data = '0;
  logic in_last = 1'b0, v4 = 1'b0, v16 = 1'b0;
  logic rd4, i4, q4, st4, ac4, dn4, un4;
  logic rd16, i16, q16, st16, ac16, dn16, un16;
  logic [1:0] idx4;
  logic [3:0] idx16;
  int n_chk = 0, n_fail = 0;

  qpsk_symbol_scheduler #(.SPS(4), .PREAMBLE_SYMS(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(v4), .in_last(in_last),
    .in_ready(rd4), .i_bit(i4), .q_bit(q4), .sample_idx(idx4), .sym_strobe(st4),
    .tx_active(ac4), .frame_done(dn4), .underrun(un4));

  qpsk_symbol_scheduler #(.SPS(16), .PREAMBLE_SYMS(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(v16), .in_last(in_last),
    .in_ready(rd16), .i_bit(i16), .q_bit(q16), .sample_idx(idx16), .sym_strobe(st16),
    .tx_active(ac16), .frame_done(dn16), .underrun(un16));

  always #5 clk = ~clk;

  typedef struct packed {
    logic i, q;
    logic [3:0] idx;
    logic strobe, active, ready, done, under;
  } obs_t;

  typedef struct packed {
    logic v;
    logic [7:0] d;
    logic l;
  } drv_t;

  typedef struct {
    bit sel;
    logic [23:0] bytes;
    int n;
    bit last;
    bit hold;
    int e_act, e_str, e_rdy, e_done, e_und;
    logic [23:0] e_dib;
  } vec_t;

  obs_t exp_q[$];
  drv_t drv_q[$];
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  function automatic obs_t act_obs(input bit sel);
    obs_t o;
    o = sel ? {i16, q16, idx16, st16, ac16, rd16, dn16, un16}
            : {i4, q4, 2'b00, idx4, st4, ac4, rd4, dn4, un4};
    return o;
  endfunction

  function automatic logic [7:0] byte_of(input vec_t v, input int j);
    return 8'(v.bytes >> (8 * (v.n - 1 - j)));
  endfunction

  function automatic obs_t mk(input logic [1:0] iq, input int s, input bit ready);
    obs_t o;
    o = '0;
    o.i = iq[1];
    o.q = iq[0];
    o.idx = 4'(s);
    o.strobe = s == 0;
    o.active = 1'b1;
    o.ready = ready;
    return o;
  endfunction

  // what the source drives: the next byte at an accepting boundary, nothing at an underrun, noise elsewhere
  function automatic drv_t pick(input bit ready, input vec_t v, input int nxt);
    drv_t d;
    d = {1'($urandom), 8'($urandom), 1'($urandom)};
    if (ready) begin
      d.v = nxt < v.n;
      if (nxt < v.n) begin
        d.d = byte_of(v, nxt);
        d.l = nxt == v.n - 1 && v.last;
      end
    end else if (v.hold) d.v = 1'b1;
    return d;
  endfunction

  // expected per-cycle output trace of one frame, starting from the IDLE cycle that sees in_valid
  task automatic build(input vec_t v);
    int sps, p;
    logic [7:0] b;
    logic [1:0] dib;
    bit lj, rdy;
    obs_t o;
    sps = v.sel ? 16 : 4;
    p = v.sel ? 8 : 2;
    exp_q.delete();
    drv_q.delete();
    exp_q.push_back('0);
    drv_q.push_back({1'b1, 8'($urandom), 1'($urandom)});
    for (int k = 0; k < p; k++)
      for (int s = 0; s < sps; s++) begin
        rdy = k == p - 1 && s == sps - 1;
        exp_q.push_back(mk((k % 2) ? 2'b11 : 2'b00, s, rdy));
        drv_q.push_back(pick(rdy, v, 0));
      end
    for (int j = 0; j < v.n; j++) begin
      b = byte_of(v, j);
      lj = j == v.n - 1 && v.last;
      for (int d = 0; d < 4; d++) begin
        dib = 2'(b >> (6 - 2 * d));
        for (int s = 0; s < sps; s++) begin
          rdy = d == 3 && s == sps - 1 && !lj;
          exp_q.push_back(mk(dib, s, rdy));
          drv_q.push_back(pick(rdy, v, j + 1));
        end
      end
    end
    o = '0;
    o.done = v.last;
    o.under = !v.last;
    exp_q.push_back(o);
    drv_q.push_back('0);
    exp_q.push_back('0);
    drv_q.push_back('0);
  endtask

  // drive the source for ncyc cycles (whole frame if negative) and compare each cycle
  task automatic run_frame(input vec_t v, input int ncyc);
    obs_t a;
    logic vld;
    int act, str, rdy, dn, un, sc, p, lim;
    logic [23:0] dib;
    act = 0; str = 0; rdy = 0; dn = 0; un = 0; sc = 0; dib = '0;
    p = v.sel ? 8 : 2;
    build(v);
    lim = ncyc < 0 ? exp_q.size() : ncyc;
    for (int c = 0; c < lim; c++) begin
      {vld, in_data, in_last} = drv_q[c];
      v4 = !v.sel && vld;
      v16 = v.sel && vld;
      @(negedge clk);
      a = act_obs(v.sel);
      check($sformatf("trace sel%0d cyc%0d", v.sel, c), 32'(a), 32'(exp_q[c]));
      act += int'(a.active);
      rdy += int'(a.ready);
      dn += int'(a.done);
      un += int'(a.under);
      if (a.strobe && a.active) begin
        str++;
        if (sc >= p) dib = {dib[21:0], a.i, a.q};
        sc++;
      end
      @(posedge clk);
      #1;
    end
    v4 = 1'b0;
    v16 = 1'b0;
    if (ncyc < 0) begin
      check("tx_active_cycles", act, v.e_act);
      check("sym_strobes", str, v.e_str);
      check("in_ready_pulses", rdy, v.e_rdy);
      check("frame_done_pulses", dn, v.e_done);
      check("underrun_pulses", un, v.e_und);
      check("data_dibits", 32'(dib), 32'(v.e_dib));
    end
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{sel:0, bytes:24'h1B, n:1, last:1, hold:0, e_act:24, e_str:6, e_rdy:1, e_done:1, e_und:0, e_dib:24'h1B};
    tbl[1] = '{sel:0, bytes:24'hE427, n:2, last:1, hold:1, e_act:40, e_str:10, e_rdy:2, e_done:1, e_und:0, e_dib:24'hE427};
    tbl[2] = '{sel:0, bytes:24'hFF, n:1, last:0, hold:0, e_act:24, e_str:6, e_rdy:2, e_done:0, e_und:1, e_dib:24'hFF};
    tbl[3] = '{sel:0, bytes:24'hA5, n:1, last:1, hold:1, e_act:24, e_str:6, e_rdy:1, e_done:1, e_und:0, e_dib:24'hA5};
    tbl[4] = '{sel:1, bytes:24'h123456, n:3, last:1, hold:0, e_act:320, e_str:20, e_rdy:3, e_done:1, e_und:0, e_dib:24'h123456};
    #1 rst_n = 1'b0;
    #1 check("reset_dut4", 32'(act_obs(0)), 0);
    check("reset_dut16", 32'(act_obs(1)), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_after_reset", 32'(act_obs(0)), 0);
    end
    @(posedge clk);
    #1;
    for (int t = 0; t < 5; t++) run_frame(tbl[t], -1);
    run_frame(tbl[1], 14);
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_data", 32'(act_obs(0)), 0);
    @(posedge clk);
    #1 check("held_in_reset", 32'(act_obs(0)), 0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("no_pulse_after_abort", 32'(act_obs(0)), 0);
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 24; r++) begin
      v.sel = r % 8 == 7;
      v.n = $urandom_range(1, 3);
      v.bytes = 24'($urandom) & 24'((1 << (8 * v.n)) - 1);
      v.last = $urandom_range(0, 3) != 0;
      v.hold = 1'($urandom);
      v.e_str = (v.sel ? 8 : 2) + 4 * v.n;
      v.e_act = v.e_str * (v.sel ? 16 : 4);
      v.e_rdy = v.n + (v.last ? 0 : 1);
      v.e_done = v.last ? 1 : 0;
      v.e_und = v.last ? 0 : 1;
      v.e_dib = v.bytes;
      run_frame(v, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
